// File: rtl/wind_acq_sequencer.sv
// Wind sensor acquisition sequencer: sample strobe, TX burst,
// receiver blanking, acquisition window and result wait.
module wind_acq_sequencer #(
  parameter int CLKDIV   = 20,
  parameter int STRBPH   = 18,
  parameter int TXLEN    = 8,
  parameter int BLANKLEN = 50,
  parameter int NSAMP    = 2000,
  parameter int TIMEOUT  = 4095
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  input  logic        abort,
  input  logic [3:0]  spdmeanlen_in,
  input  logic        speeden,
  output logic        endata,
  output logic        txen,
  output logic        acqen,
  output logic [10:0] sampcnt,
  output logic [3:0]  spdmeanlen,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    TX,
    BLANK,
    ACQ,
    WAITRES,
    DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [DW-1:0] clkdiv;
  logic [11:0]   cnt;
  logic [11:0]   cnt_n;
  logic          latch;
  logic          terr_set;
  logic [3:0]    clamp;

  always_comb begin
    clamp = spdmeanlen_in;
    unique case (1'b1)
      (spdmeanlen_in < 4'd6):  clamp = 4'd6;
      (spdmeanlen_in > 4'd11): clamp = 4'd11;
      default: ;
    endcase
  end

  // abort overrides every other transition
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    latch    = 1'b0;
    terr_set = 1'b0;
    if (abort) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_n = TX;
            cnt_n   = '0;
            latch   = 1'b1;
          end
        end
        TX: begin
          if (endata) begin
            if (cnt == 12'(TXLEN - 1)) begin
              state_n = BLANK;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 12'd1;
            end
          end
        end
        BLANK: begin
          if (endata) begin
            if (cnt == 12'(BLANKLEN - 1)) begin
              state_n = ACQ;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 12'd1;
            end
          end
        end
        ACQ: begin
          if (endata) begin
            if (cnt == 12'(NSAMP - 1)) begin
              state_n = WAITRES;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 12'd1;
            end
          end
        end
        WAITRES: begin
          if (speeden) begin
            state_n = DONE;
            cnt_n   = '0;
          end else if (endata) begin
            if (cnt == 12'(TIMEOUT - 1)) begin
              state_n  = DONE;
              cnt_n    = '0;
              terr_set = 1'b1;
            end else begin
              cnt_n = cnt + 12'd1;
            end
          end
        end
        DONE: begin
          cnt_n = '0;
          if (continuous) begin
            state_n = TX;
            latch   = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clkdiv <= '0;
      endata <= 1'b0;
    end else begin
      if (clkdiv == DW'(CLKDIV - 1)) clkdiv <= '0;
      else clkdiv <= clkdiv + DW'(1);
      endata <= (clkdiv == DW'(STRBPH));
    end
  end

  // outputs are decoded from the next state so they track state exactly
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      txen        <= 1'b0;
      acqen       <= 1'b0;
      sampcnt     <= '0;
      spdmeanlen  <= 4'd6;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      txen    <= (state_n == TX);
      acqen   <= (state_n == ACQ);
      sampcnt <= (state_n == ACQ) ? cnt_n[10:0] : 11'd0;
      busy    <= (state_n != IDLE);
      done    <= (state_n == DONE);
      if (latch) spdmeanlen <= clamp;
      if (latch) timeout_err <= 1'b0;
      else if (terr_set) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wind_acq_sequencer.sv
// Scoreboard bench for wind_acq_sequencer: directed runs push
// expected per-measurement results, a monitor checks each done.
module tb_wind_acq_sequencer;

  localparam int CLKDIV   = 20;
  localparam int STRBPH   = 18;
  localparam int TXLEN    = 4;
  localparam int BLANKLEN = 10;
  localparam int NSAMP    = 16;
  localparam int TIMEOUT  = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        abort = 1'b0;
  logic        speeden = 1'b0;
  logic [3:0]  spdmeanlen_in = 4'd0;
  logic        endata;
  logic        txen;
  logic        acqen;
  logic [10:0] sampcnt;
  logic [3:0]  spdmeanlen;
  logic        busy;
  logic        done;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         tx;
    int         blank;
    int         acq;
    int         wt;
    logic       terr;
    logic [3:0] sml;
  } exp_t;

  exp_t q[$];
  exp_t mexp;
  int   tx_n = 0;
  int   blank_n = 0;
  int   acq_n = 0;
  int   wt_n = 0;
  int   ndone = 0;
  int   idle_cyc = 0;
  bit   samp_bad = 0;

  always #5 clock = ~clock;

  wind_acq_sequencer #(
    .CLKDIV(CLKDIV), .STRBPH(STRBPH), .TXLEN(TXLEN),
    .BLANKLEN(BLANKLEN), .NSAMP(NSAMP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .continuous(continuous), .abort(abort),
    .spdmeanlen_in(spdmeanlen_in), .speeden(speeden),
    .endata(endata), .txen(txen), .acqen(acqen),
    .sampcnt(sampcnt), .spdmeanlen(spdmeanlen),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (!busy) idle_cyc++;
    if (acqen ? (endata && sampcnt != 11'(acq_n)) : (sampcnt != 11'd0))
      samp_bad = 1;
    if (endata && txen) tx_n++;
    else if (endata && acqen) acq_n++;
    else if (endata && busy) begin
      if (acq_n == 0) blank_n++;
      else wt_n++;
    end
    if (done) begin
      ndone++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done pulse, expected none");
      end else begin
        mexp = q.pop_front();
        chk("tx_strobes", tx_n, mexp.tx);
        chk("blank_strobes", blank_n, mexp.blank);
        chk("acq_strobes", acq_n, mexp.acq);
        chk("wait_strobes", wt_n, mexp.wt);
        chk("timeout_err", timeout_err, mexp.terr);
        chk("spdmeanlen", spdmeanlen, mexp.sml);
        chk("sampcnt_seq", samp_bad, 0);
      end
      samp_bad = 0;
    end
    if (done || !busy) begin
      tx_n = 0;
      blank_n = 0;
      acq_n = 0;
      wt_n = 0;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [3:0] sml);
    spdmeanlen_in = sml;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_for(input int which, input logic val,
                          input string name);
    logic s;
    for (int i = 0; i < 4000; i++) begin
      s = (which == 0) ? acqen : (which == 1) ? txen : done;
      if (s === val) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL wait_%s: timed out, required level %0b", name, val);
  endtask

  // raise speeden in the same cycle as the k-th result-wait strobe
  task automatic answer(input int k);
    int n = 0;
    wait_for(0, 1'b1, "acq_on");
    wait_for(0, 1'b0, "acq_off");
    for (int i = 0; i < 2000 && n < k; i++) begin
      if (endata) begin
        n++;
        if (n == k) speeden = 1'b1;
      end
      step();
      speeden = 1'b0;
    end
  endtask

  task automatic first_strobe(output int n);
    n = 0;
    while (!endata && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic next_strobe(output int n);
    step();
    n = 1;
    while (!endata && n < 100) begin
      step();
      n++;
    end
  endtask

  int n;
  int i0;

  initial begin
    #1 reset = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_txen", txen, 0);
    chk("rst_acqen", acqen, 0);
    chk("rst_done", done, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_sml", spdmeanlen, 6);
    chk("rst_endata", endata, 0);
    chk("rst_sampcnt", sampcnt, 0);

    reset = 1'b1;
    first_strobe(n);
    chk("first_endata", n, STRBPH + 1);
    for (int k = 0; k < 3; k++) begin
      next_strobe(n);
      chk("endata_period", n, CLKDIV);
    end
    repeat (200) step();
    chk("idle_busy", busy, 0);
    chk("idle_en", {txen, acqen}, 0);

    // normal measurement, answered 5 strobes into the wait
    q.push_back('{TXLEN, BLANKLEN, NSAMP, 5, 1'b0, 4'd8});
    pulse_start(4'd8);
    answer(5);
    wait_for(2, 1'b1, "done_norm");
    step();

    // no answer: timeout, clamp 3 -> 6
    q.push_back('{TXLEN, BLANKLEN, NSAMP, TIMEOUT, 1'b1, 4'd6});
    pulse_start(4'd3);
    answer(0);
    wait_for(2, 1'b1, "done_tmo");
    step();
    repeat (50) step();
    chk("terr_sticky", timeout_err, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk("terr_after_abort", timeout_err, 1);
    chk("busy_after_abort", busy, 0);

    // clamp 15 -> 11, ignored start, abort at sample 7
    pulse_start(4'd15);
    chk("clamp_hi", spdmeanlen, 11);
    chk("terr_cleared", timeout_err, 0);
    step();
    pulse_start(4'd6);
    chk("start_ignored", spdmeanlen, 11);
    wait_for(0, 1'b1, "acq_abort");
    for (int i = 0; i < 400; i++) begin
      if (endata && acqen && sampcnt == 11'd7) break;
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_acqen", acqen, 0);
    chk("abort_txen", txen, 0);
    repeat (300) step();
    chk("no_restart", busy, 0);

    // three back-to-back continuous cycles
    for (int k = 0; k < 3; k++)
      q.push_back('{TXLEN, BLANKLEN, NSAMP, 5, 1'b0, 4'd9});
    continuous = 1'b1;
    pulse_start(4'd9);
    i0 = idle_cyc;
    answer(5);
    answer(5);
    wait_for(1, 1'b1, "tx3");
    continuous = 1'b0;
    answer(5);
    wait_for(2, 1'b1, "done3");
    chk("no_idle_between", idle_cyc - i0, 0);
    step();
    step();
    chk("cont_end_idle", busy, 0);

    // speeden coincides with the timeout strobe
    q.push_back('{TXLEN, BLANKLEN, NSAMP, TIMEOUT, 1'b0, 4'd7});
    pulse_start(4'd7);
    answer(TIMEOUT);
    wait_for(2, 1'b1, "done_coinc");
    step();

    // reset during TX
    pulse_start(4'd10);
    wait_for(1, 1'b1, "tx_rst");
    repeat (5) step();
    #2 reset = 1'b0;
    #1;
    chk("arst_txen", txen, 0);
    chk("arst_busy", busy, 0);
    chk("arst_acqen", acqen, 0);
    chk("arst_done", done, 0);
    chk("arst_terr", timeout_err, 0);
    chk("arst_sml", spdmeanlen, 6);
    chk("arst_endata", endata, 0);
    step();
    reset = 1'b1;
    first_strobe(n);
    chk("first_endata_2", n, STRBPH + 1);
    repeat (300) step();
    chk("rst_no_restart", busy, 0);

    chk("queue_empty", q.size(), 0);
    chk("done_count", ndone, 6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
